// File: rtl/stitch_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stitch_flow_pkg
// Description : Shared helpers and types for the stitched-pipeline flow
//               controller (counter width function, status struct).
// Revision    : 1.0 - initial release
// ============================================================================
package stitch_flow_pkg;

    // Fixed width used by the status struct; wide enough for any sane depth.
    localparam int c_STATUS_CNT_W = 16;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [c_STATUS_CNT_W-1:0] inflight;
        logic                      idle;
    } flow_status_t;

    // Build the status word from the number of outstanding results.
    function automatic flow_status_t make_status(input logic [c_STATUS_CNT_W-1:0] used);
        flow_status_t s;
        s.inflight = used;
        s.idle     = (used == '0);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stitch_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stitch_out_fifo
// Description : Synchronous output FIFO for pipeline results. Pointers and
//               count reset asynchronously; storage is unreset. Read data is
//               masked to zero while empty, with no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module stitch_out_fifo
    import stitch_flow_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_empty;
    logic              w_rd;

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_rd    = rd_en & ~w_empty;
    assign count   = r_count;
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous write and read keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({wr_en, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit gating upstream must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (r_count == c_FULL)));

endmodule
`default_nettype wire

// File: rtl/stitch_pipeline_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stitch_pipeline_flow_ctrl
// Description : Valid/ready wrapper logic for a fixed-latency stitched
//               pipeline without stalls. A token shift register follows each
//               accepted input; results land in an output FIFO, and inputs are
//               only admitted while FIFO credit remains.
// Revision    : 1.0 - initial release
// ============================================================================
module stitch_pipeline_flow_ctrl
    import stitch_flow_pkg::*;
#(
    parameter  int LATENCY    = 2,
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pipe_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  inflight,
    output logic              idle
);

    localparam logic [CNT_W-1:0] c_CREDITS = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]   r_credits;
    logic [LATENCY-1:0] r_tok;
    logic               w_accept;
    logic               w_pop;
    logic               w_arrive;
    logic [CNT_W-1:0]   w_fifo_count;
    flow_status_t       w_status;

    // in_ready depends only on the credit register, never on in_valid/out_ready.
    assign in_ready  = (r_credits != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_arrive  = r_tok[LATENCY-1];
    assign out_valid = (w_fifo_count != '0);

    // One credit per FIFO slot: taken on accept, returned on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= c_CREDITS;
        end else begin
            r_credits <= r_credits - CNT_W'(w_accept) + CNT_W'(w_pop);
        end
    end

    generate
        if (LATENCY == 1) begin : g_tok_single
            // Single-stage token tracker.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tok <= '0;
                end else begin
                    r_tok <= w_accept;
                end
            end
        end else begin : g_tok_chain
            // Token chain mirroring the pipeline stages; the last bit marks a valid result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tok <= '0;
                end else begin
                    r_tok <= {r_tok[LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    // pipe_out is only meaningful on the cycle a token arrives.
    stitch_out_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_arrive),
        .wr_data (pipe_out),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .count   (w_fifo_count)
    );

    assign w_status = make_status(c_STATUS_CNT_W'(FIFO_DEPTH) - c_STATUS_CNT_W'(r_credits));
    assign inflight = w_status.inflight[CNT_W-1:0];
    assign idle     = w_status.idle;

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_credits <= c_CREDITS);

    a_status_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_status.inflight <= c_STATUS_CNT_W'(FIFO_DEPTH));

    a_fifo_within_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        w_fifo_count <= inflight);

endmodule
`default_nettype wire

// File: tb/tb_stitch_pipeline_flow_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stitch_pipeline_flow_ctrl
// Description : Scoreboard bench for the flow controller. Two instances
//               (depth 4 and depth 3) share one adder pipeline model and one
//               stimulus stream; each has its own expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stitch_pipeline_flow_ctrl;
    import stitch_flow_pkg::*;

    localparam int LATENCY = 2;
    localparam int DATA_W  = 32;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [31:0]       x         = '0;
    logic [31:0]       y         = '0;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    int                cyc   = 0;
    int                total = 0;
    int                bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stitched datapath stand-in: x+y in stage 1, registered again in stage 2.
    always @(posedge clk) begin
        s1 <= x + y;
        s2 <= s1;
    end

    task automatic check(input string name, input int depth, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s depth=%0d cyc=%0d got=%0h want=%0h", name, depth, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D  = (g == 0) ? 4 : 3;
        localparam int CW = cnt_w(D);

        logic              in_ready;
        logic              out_valid;
        logic              idle;
        logic [DATA_W-1:0] out_data;
        logic [CW-1:0]     inflight;
        logic [31:0]       exp_val[$];
        int                exp_at[$];
        int                n_acc     = 0;
        int                n_pop     = 0;
        int                acc_cnt   = 0;
        int                stall_cnt = 0;

        stitch_pipeline_flow_ctrl #(
            .LATENCY    (LATENCY),
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .pipe_out  (s2),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .inflight  (inflight),
            .idle      (idle)
        );

        // Stimulus side: every accepted input predicts a sum due LATENCY+1 cycles later.
        always begin
            @(negedge clk);
            #1;
            if (rst_n && in_valid) begin
                if (in_ready) begin
                    exp_val.push_back(x + y);
                    exp_at.push_back(cyc + LATENCY + 1);
                    n_acc++;
                    acc_cnt++;
                end else begin
                    stall_cnt++;
                end
            end
        end

        // Reset discards everything that was outstanding.
        always @(negedge rst_n) begin
            exp_val.delete();
            exp_at.delete();
            n_acc = 0;
            n_pop = 0;
        end

        // Monitor: compare handshake and head data against the queue model.
        always begin : p_mon
            int   outstanding;
            logic exp_v;
            @(negedge clk);
            if (!rst_n) begin
                check("rst_in_ready", D, in_ready, 1);
                check("rst_out_valid", D, out_valid, 0);
                check("rst_out_data", D, out_data, 0);
                check("rst_inflight", D, inflight, 0);
                check("rst_idle", D, idle, 1);
            end else begin
                outstanding = n_acc - n_pop;
                exp_v = (exp_val.size() > 0) && (exp_at[0] <= cyc);
                check("in_ready", D, in_ready, (outstanding < D) ? 1 : 0);
                check("inflight", D, inflight, outstanding);
                check("idle", D, idle, (outstanding == 0) ? 1 : 0);
                check("out_valid", D, out_valid, exp_v);
                if (exp_v) begin
                    check("out_data", D, out_data, exp_val[0]);
                    if (out_ready) begin
                        void'(exp_val.pop_front());
                        void'(exp_at.pop_front());
                        n_pop++;
                    end
                end else begin
                    check("out_data_empty", D, out_data, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r);
        in_valid  = v;
        out_ready = r;
        x = $urandom;
        y = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(g_inst[0].idle && g_inst[1].idle) && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (!(g_inst[0].idle && g_inst[1].idle)) begin
            bad++;
            $display("FAIL %s drain timeout got idle=%0b/%0b want 1/1", name,
                     g_inst[0].idle, g_inst[1].idle);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int s0;
        int len;
        int pv;
        int pr;

        // Reset held for a few cycles.
        rst_n = 1'b0;
        drive(0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single transfer 42+64.
        in_valid = 1'b1; out_ready = 1'b1; x = 32'd42; y = 32'd64;
        tick();
        drive(0, 1);
        repeat (2) tick();
        check("t1_sum_106", 4, g_inst[0].out_data, 32'd106);
        wait_idle("t1");

        // Streaming 20 inputs with no backpressure.
        s0 = g_inst[0].stall_cnt;
        a0 = g_inst[0].acc_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1);
            tick();
        end
        drive(0, 1);
        check("t2_no_stall", 4, g_inst[0].stall_cnt - s0, 0);
        check("t2_accepts", 4, g_inst[0].acc_cnt - a0, 20);
        wait_idle("t2");

        // Backpressure: exactly DEPTH accepts, then stall.
        a0 = g_inst[0].acc_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            tick();
        end
        check("t3_accepts", 4, g_inst[0].acc_cnt - a0, 4);
        check("t3_inflight", 4, g_inst[0].inflight, 4);
        check("t3_in_ready", 4, g_inst[0].in_ready, 0);

        // Pop and in_valid together at zero credit: accept waits a cycle.
        drive(1, 1);
        check("t4_ready_at_pop", 4, g_inst[0].in_ready, 0);
        tick();
        drive(1, 0);
        check("t4_ready_after_pop", 4, g_inst[0].in_ready, 1);
        tick();
        drive(1, 0);
        check("t4_accepts", 4, g_inst[0].acc_cnt - a0, 5);
        drive(0, 1);
        wait_idle("t4");

        // Reset with two tokens in the pipe and one word in the FIFO.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0);
            tick();
        end
        check("t5_pre_inflight", 4, g_inst[0].inflight, 3);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        drive(0, 1);
        repeat (8) tick();
        check("t5_idle_after", 4, g_inst[0].idle, 1);

        // Random push/pop bursts exercising pointer wrap on both depths.
        for (int b = 0; b < 10; b++) begin
            len = $urandom_range(2, 8);
            pv  = $urandom_range(1, 4);
            pr  = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                drive($urandom_range(0, 3) < pv, $urandom_range(0, 3) < pr);
                tick();
            end
        end
        drive(0, 1);
        wait_idle("t6");
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
